// File: rtl/soc_rst_pkg.sv
// Shared types for the SoC reset sequencer: FSM states, reset-cause codes and a sizing helper.
package soc_rst_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SYS_HOLD  = 3'd2,
        ST_CPU_HOLD  = 3'd3,
        ST_RUN       = 3'd4
    } rst_state_e;

    typedef logic [1:0] rst_cause_t;

    localparam rst_cause_t RST_CAUSE_POR  = 2'b00;
    localparam rst_cause_t RST_CAUSE_LOCK = 2'b01;
    localparam rst_cause_t RST_CAUSE_DBG  = 2'b10;
    localparam rst_cause_t RST_CAUSE_WDT  = 2'b11;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; output is low while cleared.
module rst_sync2 (
    input  logic clk_i,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i or negedge clr_n) begin
        if (!clr_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_rst_seq.sv
// Reset sequencer: orders system and CPU reset release after PLL lock, re-sequences on lock loss,
// debug request and (when RST_SEQ_WDT_EN is defined) watchdog timeout.
module soc_rst_seq
    import soc_rst_pkg::*;
#(
    parameter int unsigned SYS_HOLD    = 16,
    parameter int unsigned CPU_HOLD    = 32,
    parameter int unsigned LOCK_FILTER = 8,
    parameter int unsigned WDT_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    input  logic       dbg_cpu_rst_i,
    input  logic       wdt_kick_i,
    output logic       rst_sys_o,
    output logic       rst_cpu_o,
    output logic       run_o,
    output logic [1:0] rst_cause_o
);

    localparam int unsigned CNT_W =
        $clog2(max_u(max_u(SYS_HOLD, CPU_HOLD), max_u(LOCK_FILTER, WDT_TIMEOUT))) + 1;

    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rst_cause_t       cause_d;
    logic             rst_sync, lock_sync;
    logic             wdt_expire_c;

    rst_sync2 u_rst_sync (
        .clk_i (clk_i),
        .clr_n (rst_i),
        .d     (1'b1),
        .q     (rst_sync)
    );

    rst_sync2 u_lock_sync (
        .clk_i (clk_i),
        .clr_n (rst_i),
        .d     (pll_lock_i),
        .q     (lock_sync)
    );

`ifdef RST_SEQ_WDT_EN
    logic [CNT_W-1:0] wdt_q;

    // Watchdog counts only while staying in RUN; a kick always clears it, even on the expiry cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wdt_q <= '0;
        end else if (state_q != ST_RUN || state_d != ST_RUN || wdt_kick_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_q + CNT_W'(1);
        end
    end

    assign wdt_expire_c = (state_q == ST_RUN) && !wdt_kick_i
                          && (wdt_q == CNT_W'(WDT_TIMEOUT - 1));
`else
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick_i;
    assign wdt_expire_c    = 1'b0;
`endif

    // Next state, shared counter and cause; re-sequence requests override the normal progression.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = rst_cause_o;

        unique case (state_q)
            ST_RESET: begin
                cnt_d = '0;
                if (rst_sync) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!lock_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                    state_d = ST_SYS_HOLD;
                    cnt_d   = CNT_W'(SYS_HOLD - 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SYS_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CPU_HOLD;
                    cnt_d   = CNT_W'(CPU_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CPU_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase

        if (state_q inside {ST_SYS_HOLD, ST_CPU_HOLD, ST_RUN}) begin
            if (!lock_sync) begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
                cause_d = RST_CAUSE_LOCK;
            end else if (dbg_cpu_rst_i) begin
                state_d = ST_CPU_HOLD;
                cnt_d   = CNT_W'(CPU_HOLD - 1);
                cause_d = RST_CAUSE_DBG;
            end else if (wdt_expire_c) begin
                state_d = ST_CPU_HOLD;
                cnt_d   = CNT_W'(CPU_HOLD - 1);
                cause_d = RST_CAUSE_WDT;
            end
        end
    end

    // State, counter and outputs decoded from the next state so outputs are registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            rst_sys_o   <= 1'b1;
            rst_cpu_o   <= 1'b1;
            run_o       <= 1'b0;
            rst_cause_o <= RST_CAUSE_POR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_sys_o   <= state_d inside {ST_RESET, ST_WAIT_LOCK, ST_SYS_HOLD};
            rst_cpu_o   <= (state_d != ST_RUN);
            run_o       <= (state_d == ST_RUN);
            rst_cause_o <= cause_d;
        end
    end

endmodule
